// File: rtl/dht22_pkg.sv
// Shared types, timing constants and checksum helper for the DHT22 sensor emulator.
package dht22_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOST_LOW,
        RESP_DELAY,
        RESP_LOW,
        RESP_HIGH,
        BIT_LOW,
        BIT_HIGH,
        END_LOW
    } dht22_state_e;

    localparam int unsigned RESP_DELAY_US = 30;
    localparam int unsigned RESP_LOW_US   = 80;
    localparam int unsigned RESP_HIGH_US  = 80;
    localparam int unsigned BIT_LOW_US    = 50;
    localparam int unsigned BIT0_HIGH_US  = 26;
    localparam int unsigned BIT1_HIGH_US  = 70;
    localparam int unsigned END_LOW_US    = 50;

    localparam int unsigned FRAME_BITS = 40;
    localparam int unsigned TRUNC_BITS = 16;
    localparam int unsigned US_CNT_W   = 16;
    localparam int unsigned BIT_CNT_W  = 6;
    localparam int unsigned DATA_W     = 16;

    typedef struct packed {
        logic [DATA_W-1:0] humidity;
        logic [DATA_W-1:0] temperature;
        logic              inject_error;
    } dht22_shadow_t;

    // Sum of the four payload bytes, wrapped to 8 bits.
    function automatic logic [7:0] dht22_checksum(input logic [DATA_W-1:0] hum,
                                                  input logic [DATA_W-1:0] temp);
        return 8'(hum[15:8] + hum[7:0] + temp[15:8] + temp[7:0]);
    endfunction

endpackage

// File: rtl/dht22_sensor_emu_if.sv
// Host-side load/status bundle of the DHT22 sensor emulator.
interface dht22_sensor_emu_if;
    import dht22_pkg::*;

    logic              data_valid;
    logic [DATA_W-1:0] humidity;
    logic [DATA_W-1:0] temperature;
    logic              inject_error;
    logic              busy;
    logic              frame_done;

    modport master (
        output data_valid, humidity, temperature, inject_error,
        input  busy, frame_done
    );

    modport slave (
        input  data_valid, humidity, temperature, inject_error,
        output busy, frame_done
    );

endinterface

// File: rtl/dht22_us_tick.sv
// 1 us strobe generator; restart realigns the period to the restart cycle.
module dht22_us_tick #(
    parameter int unsigned CLK_FREQ = 100000000
) (
    input  logic clk,
    input  logic arstn,
    input  logic restart,
    output logic tick
);

    localparam int unsigned DIV   = CLK_FREQ / 1000000;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else if (restart) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else if (cnt_q == CNT_W'(DIV - 1)) begin
            cnt_q <= '0;
            tick  <= 1'b1;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/dht22_sensor_emu.sv
// DHT22 single-wire sensor emulator: detects the host start pulse and answers
// with a 40-bit humidity/temperature/checksum frame on an open-drain bus.
module dht22_sensor_emu
    import dht22_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 100000000,
    parameter int unsigned MIN_START_US = 500
) (
    input  logic              clk,
    input  logic              arstn,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] humidity,
    input  logic [DATA_W-1:0] temperature,
    input  logic              inject_error,
    inout  wire               dht22_in_out,
    output logic              busy,
    output logic              frame_done
);

    dht22_state_e             state_q, state_d;
    logic [US_CNT_W-1:0]      us_cnt_q, us_cnt_d;
    logic [BIT_CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0]    frame_q, frame_d;
    logic                     trunc_q, trunc_d;
    logic                     drive_q;
    dht22_shadow_t            shadow_q;

    logic                     bus_meta_q, bus_sync_q, bus_prev_q;
    logic                     bus_fall_c, bus_rise_c;
    logic                     tick;
    logic                     restart_c;
    logic [US_CNT_W-1:0]      phase_us_c;
    logic                     phase_end_c;
    logic [BIT_CNT_W-1:0]     last_bit_c;

    // Open-drain: only ever pull low, otherwise let the external pull-up win.
    assign dht22_in_out = drive_q ? 1'b0 : 1'bz;

    // Synchronizer resets to the idle-high level so reset release is not an edge.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            bus_meta_q <= 1'b1;
            bus_sync_q <= 1'b1;
            bus_prev_q <= 1'b1;
        end else begin
            bus_meta_q <= dht22_in_out;
            bus_sync_q <= bus_meta_q;
            bus_prev_q <= bus_sync_q;
        end
    end

    assign bus_fall_c = bus_prev_q & ~bus_sync_q;
    assign bus_rise_c = ~bus_prev_q & bus_sync_q;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            shadow_q <= '0;
        end else if (data_valid) begin
            shadow_q <= '{humidity: humidity, temperature: temperature,
                          inject_error: inject_error};
        end
    end

    dht22_us_tick #(.CLK_FREQ(CLK_FREQ)) u_us_tick (
        .clk     (clk),
        .arstn   (arstn),
        .restart (restart_c),
        .tick    (tick)
    );

    // Length of the current phase; BIT_HIGH depends on the bit being sent.
    always_comb begin
        phase_us_c = US_CNT_W'(RESP_DELAY_US);
        case (state_q)
            RESP_LOW:  phase_us_c = US_CNT_W'(RESP_LOW_US);
            RESP_HIGH: phase_us_c = US_CNT_W'(RESP_HIGH_US);
            BIT_LOW:   phase_us_c = US_CNT_W'(BIT_LOW_US);
            BIT_HIGH:  phase_us_c = frame_q[FRAME_BITS-1] ? US_CNT_W'(BIT1_HIGH_US)
                                                          : US_CNT_W'(BIT0_HIGH_US);
            END_LOW:   phase_us_c = US_CNT_W'(END_LOW_US);
            default:   phase_us_c = US_CNT_W'(RESP_DELAY_US);
        endcase
    end

    assign phase_end_c = tick && (us_cnt_q == (phase_us_c - US_CNT_W'(1)));
    assign last_bit_c  = trunc_q ? BIT_CNT_W'(TRUNC_BITS - 1) : BIT_CNT_W'(FRAME_BITS - 1);
    assign restart_c   = (state_d != state_q);

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        us_cnt_d  = us_cnt_q;
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        trunc_d   = trunc_q;

        if (tick && (us_cnt_q != '1)) begin
            us_cnt_d = us_cnt_q + US_CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (bus_fall_c) state_d = HOST_LOW;
            end
            HOST_LOW: begin
                if (bus_rise_c) begin
                    if (us_cnt_q >= US_CNT_W'(MIN_START_US)) begin
                        state_d   = RESP_DELAY;
                        frame_d   = {shadow_q.humidity, shadow_q.temperature,
                                     dht22_checksum(shadow_q.humidity, shadow_q.temperature)};
                        trunc_d   = shadow_q.inject_error;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            RESP_DELAY: if (phase_end_c) state_d = RESP_LOW;
            RESP_LOW:   if (phase_end_c) state_d = RESP_HIGH;
            RESP_HIGH:  if (phase_end_c) state_d = BIT_LOW;
            BIT_LOW:    if (phase_end_c) state_d = BIT_HIGH;
            BIT_HIGH: begin
                if (phase_end_c) begin
                    if (bit_cnt_q == last_bit_c) begin
                        state_d = END_LOW;
                    end else begin
                        state_d   = BIT_LOW;
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        frame_d   = {frame_q[FRAME_BITS-2:0], 1'b0};
                    end
                end
            end
            END_LOW:    if (phase_end_c) state_d = IDLE;
            default:    state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            us_cnt_d = '0;
        end
    end

    // State register; bus drive and status are registered off the next state.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q    <= IDLE;
            us_cnt_q   <= '0;
            bit_cnt_q  <= '0;
            frame_q    <= '0;
            trunc_q    <= 1'b0;
            drive_q    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            us_cnt_q   <= us_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            frame_q    <= frame_d;
            trunc_q    <= trunc_d;
            drive_q    <= (state_d == RESP_LOW) || (state_d == BIT_LOW) || (state_d == END_LOW);
            busy       <= !((state_d == IDLE) || (state_d == HOST_LOW));
            frame_done <= (state_q == END_LOW) && (state_d == IDLE);
        end
    end

endmodule

// File: tb/tb_dht22_sensor_emu.sv
// Self-checking bench: acts as the single-wire host, decodes the emulator's
// pulse train and compares it with a byte-level model of the frame.
module tb_dht22_sensor_emu;

    localparam int unsigned CLK_FREQ     = 2000000;
    localparam int unsigned MIN_START_US = 500;
    localparam int          DIV          = int'(CLK_FREQ / 1000000);

    logic clk      = 1'b0;
    logic arstn    = 1'b0;
    logic host_low = 1'b0;
    wire  bus;

    int n_tests  = 0;
    int n_fail   = 0;
    int fd_count = 0;

    dht22_sensor_emu_if hif ();

    pullup (bus);
    assign bus = host_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    dht22_sensor_emu #(
        .CLK_FREQ     (CLK_FREQ),
        .MIN_START_US (MIN_START_US)
    ) dut (
        .clk          (clk),
        .arstn        (arstn),
        .data_valid   (hif.data_valid),
        .humidity     (hif.humidity),
        .temperature  (hif.temperature),
        .inject_error (hif.inject_error),
        .dht22_in_out (bus),
        .busy         (hif.busy),
        .frame_done   (hif.frame_done)
    );

    always @(negedge clk) begin
        if (hif.frame_done === 1'b1) fd_count++;
    end

    // Reference frame: humidity bytes, temperature bytes, byte sum mod 256.
    function automatic logic [39:0] model_frame(input logic [15:0] h, input logic [15:0] t);
        int s;
        s = (32'(h) / 256) + (32'(h) % 256) + (32'(t) / 256) + (32'(t) % 256);
        return {h, t, 8'(s % 256)};
    endfunction

    function automatic bit out_of_tol(input int cyc, input int us);
        int d;
        d = cyc - us * DIV;
        return (d > DIV) || (d < -DIV);
    endfunction

    // Counts negedges while the bus holds lvl; gives up after limit cycles.
    task automatic measure(input logic lvl, input int limit, output int cyc, output bit to);
        cyc = 0;
        to  = 1'b0;
        while (bus === lvl) begin
            @(negedge clk);
            cyc++;
            if (cyc >= limit) begin
                to = 1'b1;
                break;
            end
        end
    endtask

    task automatic load_values(input logic [15:0] h, input logic [15:0] t, input logic err);
        @(negedge clk);
        hif.humidity     = h;
        hif.temperature  = t;
        hif.inject_error = err;
        hif.data_valid   = 1'b1;
        @(negedge clk);
        hif.data_valid   = 1'b0;
    endtask

    // Issue a start pulse, decode nbits from the response and check everything.
    task automatic run_frame(input logic [15:0] h, input logic [15:0] t, input int nbits,
                             input int host_us, input string name);
        logic [39:0] exp_w, rx;
        int          cyc, terr, fd0;
        bit          to, b;
        exp_w = model_frame(h, t) >> (40 - nbits);
        rx    = '0;
        terr  = 0;
        fd0   = fd_count;

        host_low = 1'b1;
        repeat (host_us * DIV) @(negedge clk);
        host_low = 1'b0;
        @(negedge clk);
        measure(1'b1, 300 * DIV, cyc, to);
        n_tests++;
        if (to || cyc < 29 * DIV || cyc > 33 * DIV) begin
            n_fail++;
            $display("FAIL %s resp_delay: got %0d cycles timeout=%0d, required about %0d",
                     name, cyc, to, 30 * DIV);
            return;
        end
        n_tests++;
        if (hif.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy_in_frame: got %b, required 1", name, hif.busy);
        end

        measure(1'b0, 300 * DIV, cyc, to);
        if (to || out_of_tol(cyc, 80)) terr++;
        measure(1'b1, 300 * DIV, cyc, to);
        if (to || out_of_tol(cyc, 80)) terr++;
        for (int i = 0; i < nbits && !to; i++) begin
            measure(1'b0, 300 * DIV, cyc, to);
            if (to || out_of_tol(cyc, 50)) terr++;
            if (!to) begin
                measure(1'b1, 300 * DIV, cyc, to);
                b = (cyc > 48 * DIV);
                if (to || out_of_tol(cyc, b ? 70 : 26)) terr++;
                rx = {rx[38:0], b};
            end
        end
        if (!to) begin
            measure(1'b0, 300 * DIV, cyc, to);
            if (to || out_of_tol(cyc, 50)) terr++;
        end

        n_tests++;
        if (terr !== 0) begin
            n_fail++;
            $display("FAIL %s timing: got %0d bad phases, required 0", name, terr);
        end
        n_tests++;
        if (rx !== exp_w) begin
            n_fail++;
            $display("FAIL %s bits: got %h, required %h", name, rx, exp_w);
        end
        measure(1'b1, 100 * DIV, cyc, to);
        n_tests++;
        if (!to) begin
            n_fail++;
            $display("FAIL %s trailing_drive: bus went low %0d cycles after end, required idle",
                     name, cyc);
        end
        n_tests++;
        if (fd_count !== fd0 + 1) begin
            n_fail++;
            $display("FAIL %s frame_done_count: got %0d, required %0d", name, fd_count - fd0, 1);
        end
        n_tests++;
        if (hif.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy_after: got %b, required 0", name, hif.busy);
        end
    endtask

    task automatic test_reset();
        arstn = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (bus !== 1'b1 || hif.busy !== 1'b0 || hif.frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got bus=%b busy=%b done=%b, required 1 0 0",
                     bus, hif.busy, hif.frame_done);
        end
        arstn = 1'b1;
        repeat (20) @(negedge clk);
        n_tests++;
        if (hif.busy !== 1'b0 || fd_count !== 0 || bus !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_idle: got busy=%b done_count=%0d bus=%b, required 0 0 1",
                     hif.busy, fd_count, bus);
        end
    endtask

    task automatic test_main_frame();
        load_values(16'd652, 16'h8065, 1'b0);
        run_frame(16'd652, 16'h8065, 40, 1000, "main");
    endtask

    task automatic test_short_pulse();
        int viol, fd0;
        viol = 0;
        fd0  = fd_count;
        host_low = 1'b1;
        repeat (200 * DIV) @(negedge clk);
        n_tests++;
        if (hif.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL short_busy_host_low: got %b, required 0", hif.busy);
        end
        host_low = 1'b0;
        repeat (300 * DIV) begin
            @(negedge clk);
            if (bus !== 1'b1 || hif.busy !== 1'b0) viol++;
        end
        n_tests++;
        if (viol !== 0 || fd_count !== fd0) begin
            n_fail++;
            $display("FAIL short_pulse: got %0d drive/busy cycles and %0d done pulses, required 0 0",
                     viol, fd_count - fd0);
        end
    endtask

    task automatic test_inject_error();
        logic [15:0] h, t;
        h = 16'($urandom);
        t = 16'($urandom);
        load_values(h, t, 1'b1);
        run_frame(h, t, 16, 550, "inject_error");
    endtask

    task automatic test_midframe_update();
        logic [15:0] h, t;
        h = 16'($urandom_range(0, 1000));
        t = 16'($urandom);
        load_values(h, t, 1'b0);
        fork
            run_frame(h, t, 40, 550, "old_values");
            begin
                repeat (1500 * DIV) @(negedge clk);
                load_values(16'd999, 16'd900, 1'b0);
            end
        join
        run_frame(16'd999, 16'd900, 40, 550, "new_values");
    endtask

    task automatic test_reset_midframe();
        int k;
        load_values(16'($urandom), 16'($urandom), 1'b0);
        host_low = 1'b1;
        repeat (550 * DIV) @(negedge clk);
        host_low = 1'b0;
        repeat ((190 + 20 * 98) * DIV) @(negedge clk);
        k = 0;
        while (bus !== 1'b0 && k < 200 * DIV) begin
            @(negedge clk);
            k++;
        end
        repeat (10) @(negedge clk);
        n_tests++;
        if (bus !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_pre: got bus=%b, required 0 (low phase)", bus);
        end
        arstn = 1'b0;
        #1;
        n_tests++;
        if (bus !== 1'b1 || hif.busy !== 1'b0 || hif.frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_release: got bus=%b busy=%b done=%b, required 1 0 0",
                     bus, hif.busy, hif.frame_done);
        end
        repeat (5) @(negedge clk);
        arstn = 1'b1;
        repeat (5) @(negedge clk);
        // Shadow registers were cleared by reset, so the next frame is all zeros.
        run_frame(16'd0, 16'd0, 40, 550, "after_reset");
    endtask

    task automatic test_random_frames();
        logic [15:0] h, t;
        for (int i = 0; i < 2; i++) begin
            h = 16'($urandom_range(0, 1000));
            t = {1'($urandom), 15'($urandom_range(0, 800))};
            load_values(h, t, 1'b0);
            run_frame(h, t, 40, 550, "random");
        end
    endtask

    initial begin
        hif.data_valid   = 1'b0;
        hif.humidity     = '0;
        hif.temperature  = '0;
        hif.inject_error = 1'b0;
        test_reset();
        test_main_frame();
        test_short_pulse();
        test_inject_error();
        test_midframe_update();
        test_reset_midframe();
        test_random_frames();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
